// File: rtl/blaster_uart_bridge_if.sv
// Command-side byte streams of blaster_uart_bridge: received bytes out, bytes to transmit in.
// master = the bridge, slave = the JTAG/Active-Serial command logic.
interface blaster_uart_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input  rx_ready, tx_data, tx_valid);
  modport slave  (input  rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/blaster_uart_bridge.sv
// 8N1 UART <-> ready/valid byte bridge with FWFT FIFOs, RTS/CTS and a runtime baud divisor.
// Optional internal loopback is built only when BLASTER_LOOPBACK_EN is defined.
module blaster_uart_bridge #(
  parameter int DIV_W      = 16,
  parameter int FIFO_AW    = 4,
  parameter int RTS_MARGIN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  blaster_uart_bridge_if.master stream,
  input  logic [DIV_W-1:0]      i_div,
  input  logic                  i_rx,
  output logic                  o_tx,
  input  logic                  i_cts_n,
  output logic                  o_rts_n,
  output logic [FIFO_AW:0]      o_rx_level,
  output logic [FIFO_AW:0]      o_tx_level,
  output logic                  o_overflow,
  output logic                  o_frame_err,
  input  logic                  i_clr_err,
  input  logic                  i_loopback
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] RTS_L   = (FIFO_AW + 1)'(RTS_MARGIN);
  localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t rx_state_r;
  tx_state_t tx_state_r;
  logic [DIV_W-1:0] div_eff_s, rx_cnt_r, rx_div_r, tx_cnt_r, tx_div_r;
  logic [2:0] rx_bit_r, tx_bit_r;
  logic [7:0] rx_shift_r, rx_byte_r, tx_shift_r;
  logic rx_push_r, frame_set_r, tx_line_r, tx_pop_s;
  logic rx_in_s, cts_ok_s;
  logic rx_sync1_r, rx_sync2_r, rx_prev_r, cts_sync1_r, cts_sync2_r;
  logic [7:0] rx_mem_r [DEPTH];
  logic [7:0] tx_mem_r [DEPTH];
  logic [FIFO_AW-1:0] rx_wr_r, rx_rd_r, tx_wr_r, tx_rd_r;
  logic [FIFO_AW:0] rx_level_r, rx_level_nxt_s, tx_level_r, tx_level_nxt_s;
  logic rx_valid_r, tx_ready_r, rx_pop_s, rx_wen_s, rx_ovf_set_s, tx_push_s;
  logic overflow_r, frame_err_r, rts_n_r;

`ifdef BLASTER_LOOPBACK_EN
  assign rx_in_s  = i_loopback ? tx_line_r : i_rx;
  assign cts_ok_s = i_loopback | ~cts_sync2_r;
  assign o_tx     = i_loopback | tx_line_r;
`else
  logic unused_loopback_s;
  assign unused_loopback_s = i_loopback;
  assign rx_in_s  = i_rx;
  assign cts_ok_s = ~cts_sync2_r;
  assign o_tx     = tx_line_r;
`endif

  // Divisors below 2 cannot place a mid-bit sample, so they are clamped.
  always_comb begin
    if (i_div < DIV_W'(2)) div_eff_s = DIV_W'(2);
    else                   div_eff_s = i_div;
  end

  // Two-stage synchronisers for the asynchronous line inputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      {rx_sync1_r, rx_sync2_r, rx_prev_r}   <= 3'b111;
      {cts_sync1_r, cts_sync2_r}            <= 2'b11;
    end else begin
      {rx_prev_r, rx_sync2_r, rx_sync1_r}   <= {rx_sync2_r, rx_sync1_r, rx_in_s};
      {cts_sync2_r, cts_sync1_r}            <= {cts_sync1_r, i_cts_n};
    end
  end

  // Receiver: START holds div/2 to land every later sample mid-bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_state_r <= RX_IDLE;   rx_cnt_r   <= {DIV_W{1'b0}}; rx_div_r  <= DIV_W'(2);
      rx_bit_r   <= 3'd0;      rx_shift_r <= 8'h00;         rx_byte_r <= 8'h00;
      rx_push_r  <= 1'b0;      frame_set_r <= 1'b0;
    end else begin
      rx_push_r   <= 1'b0;
      frame_set_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (rx_prev_r && !rx_sync2_r) begin
            rx_div_r   <= div_eff_s;
            rx_cnt_r   <= div_eff_s >> 1;
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_r > DIV_W'(1)) rx_cnt_r <= rx_cnt_r - DIV_W'(1);
          else if (rx_sync2_r)      rx_state_r <= RX_IDLE;
          else begin
            rx_cnt_r <= rx_div_r; rx_bit_r <= 3'd0; rx_state_r <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r > DIV_W'(1)) rx_cnt_r <= rx_cnt_r - DIV_W'(1);
          else begin
            rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
            rx_cnt_r   <= rx_div_r;
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
            else                  rx_bit_r   <= rx_bit_r + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r > DIV_W'(1)) rx_cnt_r <= rx_cnt_r - DIV_W'(1);
          else if (rx_sync2_r) begin
            rx_push_r <= 1'b1; rx_byte_r <= rx_shift_r; rx_state_r <= RX_IDLE;
          end else begin
            frame_set_r <= 1'b1; rx_state_r <= RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_sync2_r) rx_state_r <= RX_IDLE;
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  assign rx_pop_s     = rx_valid_r & stream.rx_ready;
  assign rx_wen_s     = rx_push_r & ((rx_level_r != DEPTH_L) | rx_pop_s);
  assign rx_ovf_set_s = rx_push_r & (rx_level_r == DEPTH_L) & ~rx_pop_s;
  assign tx_push_s    = stream.tx_valid & tx_ready_r;

  // Next FIFO occupancies; push and pop together leave the level unchanged.
  always_comb begin
    case ({rx_wen_s, rx_pop_s})
      2'b10:   rx_level_nxt_s = rx_level_r + LVL_ONE;
      2'b01:   rx_level_nxt_s = rx_level_r - LVL_ONE;
      default: rx_level_nxt_s = rx_level_r;
    endcase
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_level_nxt_s = tx_level_r + LVL_ONE;
      2'b01:   tx_level_nxt_s = tx_level_r - LVL_ONE;
      default: tx_level_nxt_s = tx_level_r;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the levels.
  always_ff @(posedge i_clk) begin
    if (rx_wen_s)  rx_mem_r[rx_wr_r] <= rx_byte_r;
    if (tx_push_s) tx_mem_r[tx_wr_r] <= stream.tx_data;
  end

  // FIFO pointers, levels and the registered valid/ready flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_wr_r <= {FIFO_AW{1'b0}}; rx_rd_r <= {FIFO_AW{1'b0}}; rx_level_r <= {(FIFO_AW+1){1'b0}};
      tx_wr_r <= {FIFO_AW{1'b0}}; tx_rd_r <= {FIFO_AW{1'b0}}; tx_level_r <= {(FIFO_AW+1){1'b0}};
      rx_valid_r <= 1'b0; tx_ready_r <= 1'b0;
    end else begin
      if (rx_wen_s)  rx_wr_r <= rx_wr_r + PTR_ONE;
      if (rx_pop_s)  rx_rd_r <= rx_rd_r + PTR_ONE;
      if (tx_push_s) tx_wr_r <= tx_wr_r + PTR_ONE;
      if (tx_pop_s)  tx_rd_r <= tx_rd_r + PTR_ONE;
      rx_level_r <= rx_level_nxt_s;
      tx_level_r <= tx_level_nxt_s;
      rx_valid_r <= rx_level_nxt_s != {(FIFO_AW+1){1'b0}};
      tx_ready_r <= tx_level_nxt_s != DEPTH_L;
    end
  end

  // A new frame may start from IDLE or straight out of a finished stop bit.
  always_comb begin
    tx_pop_s = 1'b0;
    if ((tx_level_r != {(FIFO_AW+1){1'b0}}) && cts_ok_s) begin
      case (tx_state_r)
        TX_IDLE: tx_pop_s = 1'b1;
        TX_STOP: tx_pop_s = (tx_cnt_r <= DIV_W'(1));
        default: tx_pop_s = 1'b0;
      endcase
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // Transmitter: each bit is held for the divisor latched at the start bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_r <= TX_IDLE; tx_cnt_r <= {DIV_W{1'b0}}; tx_div_r <= DIV_W'(2);
      tx_bit_r   <= 3'd0;    tx_shift_r <= 8'h00;       tx_line_r <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE, TX_STOP: begin
          if (tx_state_r == TX_STOP && tx_cnt_r > DIV_W'(1)) tx_cnt_r <= tx_cnt_r - DIV_W'(1);
          else if (tx_pop_s) begin
            tx_shift_r <= tx_mem_r[tx_rd_r];
            tx_div_r   <= div_eff_s;
            tx_cnt_r   <= div_eff_s;
            tx_line_r  <= 1'b0;
            tx_state_r <= TX_START;
          end else begin
            tx_line_r  <= 1'b1;
            tx_state_r <= TX_IDLE;
          end
        end
        TX_START, TX_DATA: begin
          if (tx_cnt_r > DIV_W'(1)) tx_cnt_r <= tx_cnt_r - DIV_W'(1);
          else begin
            tx_cnt_r <= tx_div_r;
            if (tx_state_r == TX_DATA && tx_bit_r == 3'd7) begin
              tx_line_r  <= 1'b1;
              tx_state_r <= TX_STOP;
            end else begin
              tx_line_r  <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_bit_r   <= (tx_state_r == TX_START) ? 3'd0 : tx_bit_r + 3'd1;
              tx_state_r <= TX_DATA;
            end
          end
        end
        default: tx_state_r <= TX_IDLE;
      endcase
    end
  end

  // Sticky error flags (a same-cycle set beats the clear) and registered RTS.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_r <= 1'b0; frame_err_r <= 1'b0; rts_n_r <= 1'b1;
    end else begin
      overflow_r  <= rx_ovf_set_s | (overflow_r & ~i_clr_err);
      frame_err_r <= frame_set_r  | (frame_err_r & ~i_clr_err);
      rts_n_r     <= (DEPTH_L - rx_level_r) < RTS_L;
    end
  end

  assign stream.rx_data  = rx_mem_r[rx_rd_r];
  assign stream.rx_valid = rx_valid_r;
  assign stream.tx_ready = tx_ready_r;
  assign o_rx_level      = rx_level_r;
  assign o_tx_level      = tx_level_r;
  assign o_overflow      = overflow_r;
  assign o_frame_err     = frame_err_r;
  assign o_rts_n         = rts_n_r;
endmodule

// File: doc/blaster_uart_bridge.md
Name: blaster_uart_bridge

Overview:
- Parametrised UART-to-byte-stream bridge that sits between the host serial link and the JTAG/Active-Serial command logic.
- Contains an 8N1 UART receiver and transmitter, two first-word-fall-through (FWFT) FIFOs with configurable depth, and RTS/CTS hardware flow control.
- The bit period is a runtime-programmable divisor, not a fixed build-time constant.
- The command side sees ready/valid byte streams in both directions.

Parameters:
- DIV_W, 16, width of the runtime baud divisor input.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries per direction.
- RTS_MARGIN, 4, free RX FIFO entries below which o_rts_n deasserts.

Ports:
- i_clk  in  1  primary clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_div  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2.
- i_rx  in  1  UART serial input, asynchronous.
- o_tx  out  1  UART serial output, idle high.
- i_cts_n  in  1  peer clear-to-send, active-low, asynchronous.
- o_rts_n  out  1  request-to-send to the peer, active-low.
- o_rx_data  out  8  head byte of the RX FIFO.
- o_rx_valid  out  1  RX FIFO not empty.
- i_rx_ready  in  1  consumer pops the head when o_rx_valid && i_rx_ready.
- i_tx_data  in  8  byte to transmit.
- i_tx_valid  in  1  producer offers i_tx_data.
- o_tx_ready  out  1  TX FIFO not full.
- o_rx_level  out  FIFO_AW+1  RX FIFO occupancy.
- o_tx_level  out  FIFO_AW+1  TX FIFO occupancy.
- o_overflow  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- o_frame_err  out  1  sticky: a stop bit was sampled low.
- i_clr_err  in  1  synchronous clear of both sticky flags.
- i_loopback  in  1  internal loopback select (see Optional Feature).

Behaviour:
- Reset values:
  - o_tx=1, o_rts_n=1, o_rx_valid=0, o_tx_ready=0 during reset.
  - o_tx_ready=1 from the first clock after reset release.
  - Levels=0, sticky flags=0, both FIFOs empty, both UART FSMs IDLE.
  - A reset mid-frame aborts the frame immediately; o_tx returns high asynchronously.
- Synchronisers: i_rx and i_cts_n each pass through a 2-FF synchroniser; the synchronised i_rx resets to 1.
- Divisor latching:
  - The divisor is latched into each FSM at frame start.
  - A change to i_div mid-frame takes effect on the next frame only.
- RX FSM, states IDLE -> START -> DATA -> STOP:
  - IDLE: a synchronised falling edge enters START and loads the counter with div/2 (integer floor).
  - START: at count expiry, resample the line. If high, treat as a glitch and return to IDLE with no flag set. If low, move to DATA.
  - DATA: 8 samples, each one div apart, LSB first.
  - STOP: sample once after div cycles.
    - Stop bit 1: push the byte to the RX FIFO.
    - Stop bit 0: discard the byte, set o_frame_err, and wait for the line to return high before re-entering IDLE.
- RX push rules:
  - Push when full with a simultaneous pop: the byte is accepted.
  - Push when full with no pop: the byte is dropped, o_overflow is set, and FIFO contents are unchanged.
- TX FSM, states IDLE -> START -> DATA -> STOP:
  - IDLE: when the TX FIFO is non-empty and the synchronised CTS is low, pop the FIFO.
  - o_tx falls to the start bit on the clock after the pop.
  - Each bit lasts div cycles, LSB first; the stop bit lasts div cycles, then the FSM returns to IDLE.
  - Back-to-back bytes have no idle gap.
  - CTS is checked only in IDLE. Deasserting CTS mid-frame completes the current frame, then the FSM holds in IDLE.
- FIFOs:
  - Synchronous on posedge i_clk with FWFT output.
  - Simultaneous push and pop leave the level unchanged.
  - Pointers wrap modulo depth; the level is a separate FIFO_AW+1-bit counter.
  - A TX push is accepted only when o_tx_ready is high; i_tx_valid with o_tx_ready low is ignored.
- Flow control:
  - o_rts_n is registered: o_rts_n = (depth - o_rx_level) < RTS_MARGIN.
  - It updates one cycle after the level changes.
- Sticky flags:
  - i_clr_err clears both flags.
  - If a set event occurs in the same cycle as i_clr_err, set wins.

Optional Feature:
- BLASTER_LOOPBACK_EN defined:
  - When i_loopback=1, the TX serial stream feeds the RX synchroniser input in place of i_rx.
  - o_tx is held at 1.
  - Internal CTS is forced asserted.
  - Switching i_loopback mid-frame may corrupt that frame only.
- BLASTER_LOOPBACK_EN undefined: i_loopback is ignored and no loopback mux is synthesised.

Test Plan:
- i_div=25, rx frame 0xA5 -> o_rx_valid rises; o_rx_data=0xA5; o_rx_level=1; no flags set.
- Push 0x3C with CTS low, i_div=10 -> o_tx falls one cycle after the pop; bits 0,0,1,1,1,1,0,0 at 10 clocks each; stop high; 100 clocks total.
- FIFO_AW=4, i_rx_ready=0, send 17 frames -> level=16, o_overflow=1, 17th byte lost. With RTS_MARGIN=4, o_rts_n=1 from level 13 onward.
- Rx frame 0x55 with stop bit 0 -> o_frame_err=1, level unchanged; i_clr_err clears it. A 5-clock low glitch with i_div=25 leaves no byte and no flag.
- CTS deasserted mid-frame with 2 bytes queued -> current frame completes, second byte is held; CTS low -> second byte starts.
- Loopback (macro defined, i_loopback=1): push 0x00, 0xFF, 0x81 -> same bytes appear on o_rx_data in order; o_tx stays 1. Assert i_reset_n low mid-frame -> o_tx=1 and levels=0 immediately.
